if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/if_stage_if.sv | 24 ++
 rtl/if_id_reg.sv | 43 ++++
 rtl/if_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// pipe_pkg : shared pipeline constants, fetch FSM encoding and small helpers.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        REDIR = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [31:0] instr);
        return pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
//------------------------------------------------------------------------------
// if_stage_if : instruction memory read bus (address out, data back same cycle).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface if_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/if_id_reg.sv
//------------------------------------------------------------------------------
// if_id_reg : IF/ID pipeline register with hold (stall) and bubble (flush).
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_id_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        write_en,
    input  wire logic        flush,
    input  wire logic [31:0] fetch_instr,
    input  wire logic [31:0] fetch_pc_plus4,
    output logic      [31:0] instr,
    output logic      [31:0] pc_plus4,
    output logic             valid
);

    // A stall (write_en low) freezes everything, so a pending flush waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (write_en) begin
            pc_plus4 <= fetch_pc_plus4;
            if (flush) begin
                instr <= NOP_INSTR;
                valid <= 1'b0;
            end else begin
                instr <= fetch_instr;
                valid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// if_stage : instruction fetch stage (PC, next-PC select, fetch FSM, IF/ID reg).
//            Define IF_PERF_CNT_EN to build the stall/flush performance counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        PCWrite,
    input  wire logic        IFWrite,
    input  wire logic        IFflush,
    input  wire logic        Jump,
    input  wire logic        Branch,
    input  wire logic        Compare_Zero,
    if_stage_if.master       imem,
    output logic      [31:0] pc,
    output logic      [31:0] ID_instr,
    output logic      [31:0] ID_pc_plus4,
    output logic             ID_valid,
    output logic      [1:0]  fetch_state,
    output logic      [31:0] stall_cnt,
    output logic      [31:0] flush_cnt
);

    logic [31:0]  pc_plus4;
    logic [31:0]  br_target;
    logic [31:0]  j_target;
    logic [31:0]  pc_next;
    logic         taken_branch;
    logic         redirect;
    logic         stall_req;
    logic         id_valid_raw;
    fetch_state_t state;
    fetch_state_t state_next;

    assign pc_plus4     = pc + 32'd4;
    assign br_target    = branch_target(ID_pc_plus4, ID_instr);
    assign j_target     = jump_target(ID_pc_plus4, ID_instr);
    assign taken_branch = Branch & Compare_Zero;
    assign redirect     = PCWrite & (Jump | taken_branch);
    assign stall_req    = ~PCWrite | ~IFWrite;

    assign imem.imem_addr = pc;

    always_comb begin
        pc_next = pc_plus4;
        if (!PCWrite) begin
            pc_next = pc;
        end else if (Jump) begin
            pc_next = j_target;
        end else if (taken_branch) begin
            pc_next = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    if_id_reg #(
        .NOP_INSTR      (NOP_INSTR)
    ) u_if_id_reg (
        .clk            (clk),
        .reset          (reset),
        .write_en       (IFWrite),
        .flush          (IFflush),
        .fetch_instr    (imem.imem_rdata),
        .fetch_pc_plus4 (pc_plus4),
        .instr          (ID_instr),
        .pc_plus4       (ID_pc_plus4),
        .valid          (id_valid_raw)
    );

    // Nothing has been fetched yet while in BOOT.
    assign ID_valid = id_valid_raw & (state != BOOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN, REDIR: begin
                if (redirect) begin
                    state_next = REDIR;
                end else if (stall_req) begin
                    state_next = STALL;
                end else begin
                    state_next = RUN;
                end
            end
            STALL: begin
                if (stall_req) begin
                    state_next = STALL;
                end else if (redirect) begin
                    state_next = REDIR;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign fetch_state = state;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!PCWrite) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (IFWrite & IFflush) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire
